// File: rtl/mem_pkg.sv
// Shared definitions for the bus memory responder: size-bit indices, FSM states, default depth.
package mem_pkg;

  localparam int unsigned MS_LB  = 3;
  localparam int unsigned MS_LBU = 2;
  localparam int unsigned MS_LH  = 1;
  localparam int unsigned MS_LHU = 0;

  localparam int unsigned MEM_DEPTH_WORDS_DEFAULT = 131072;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DATA
  } mem_state_t;

endpackage

// File: rtl/mem_lane_fmt.sv
// Combinational lane logic: load extraction/extension and store byte-enable/lane replication.
module mem_lane_fmt
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  rd_lane,
  input  logic [3:0]  rd_size,
  input  logic [31:0] store_data,
  input  logic [1:0]  wr_lane,
  input  logic [3:0]  wr_size,
  output logic [31:0] rd_data,
  output logic [3:0]  wr_be,
  output logic [31:0] wr_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    unique case (rd_lane)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
    half_sel = rd_lane[1] ? word[31:16] : word[15:0];

    if (rd_size[MS_LB])
      rd_data = {{24{byte_sel[7]}}, byte_sel};
    else if (rd_size[MS_LBU])
      rd_data = {24'h0, byte_sel};
    else if (rd_size[MS_LH])
      rd_data = {{16{half_sel[15]}}, half_sel};
    else if (rd_size[MS_LHU])
      rd_data = {16'h0, half_sel};
    else
      rd_data = word;
  end

  // Store data is replicated across lanes so the enables alone pick the target bytes.
  always_comb begin
    if (wr_size[MS_LB]) begin
      wr_be   = 4'b0001 << wr_lane;
      wr_data = {4{store_data[7:0]}};
    end else if (wr_size[MS_LH]) begin
      wr_be   = wr_lane[1] ? 4'b1100 : 4'b0011;
      wr_data = {2{store_data[15:0]}};
    end else begin
      wr_be   = '1;
      wr_data = store_data;
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Word-organised RAM answering the control unit's read/write requests with a wait-state read FSM.
// The RAM starts at zero; INIT_FILE is retained for parameter compatibility and is unused.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = MEM_DEPTH_WORDS_DEFAULT,
  parameter int unsigned WAIT_STATES = 1,
  parameter string       INIT_FILE   = "mem.hex"
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] addr,
  input  logic [31:0] bus,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [3:0]  mem_size,
  input  logic        mem_addr_ready,
  output logic        mem_data_ready,
  output logic [31:0] mem_bus_out,
  output logic        mem_bus_drive
);

  localparam int unsigned AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

  logic [31:0] ram [DEPTH_WORDS] = '{default: '0};

  mem_state_t    state, state_nx;
  logic [3:0]    wait_cnt, wait_cnt_nx;
  logic [31:0]   lat_addr;
  logic [3:0]    lat_size;
  logic          load_req, fire;
  logic          data_ready;
  logic [31:0]   bus_out;

  logic [31:0]   rd_addr;
  logic [3:0]    rd_size;
  logic [31:0]   rd_word, rd_fmt;
  logic          rd_in_range, wr_in_range;
  logic [AW-1:0] rd_idx, wr_idx;
  logic [3:0]    wr_be;
  logic [31:0]   wr_data;

  // With zero wait states the read fires straight from IDLE, so it must use the live request.
  assign rd_addr     = (state == IDLE) ? addr : lat_addr;
  assign rd_size     = (state == IDLE) ? mem_size : lat_size;
  assign rd_in_range = (rd_addr >> 2) < DEPTH_WORDS;
  assign wr_in_range = (addr >> 2) < DEPTH_WORDS;
  assign rd_idx      = rd_addr[AW+1:2];
  assign wr_idx      = addr[AW+1:2];
  assign rd_word     = rd_in_range ? ram[rd_idx] : '0;

  mem_lane_fmt u_fmt (
    .word       (rd_word),
    .rd_lane    (rd_addr[1:0]),
    .rd_size    (rd_size),
    .store_data (bus),
    .wr_lane    (addr[1:0]),
    .wr_size    (mem_size),
    .rd_data    (rd_fmt),
    .wr_be      (wr_be),
    .wr_data    (wr_data)
  );

  always_comb begin
    state_nx    = state;
    wait_cnt_nx = wait_cnt;
    load_req    = 1'b0;
    fire        = 1'b0;
    unique case (state)
      IDLE: begin
        if (mem_read && mem_addr_ready && !mem_write) begin
          load_req = 1'b1;
          if (WAIT_STATES == 0) begin
            state_nx = DATA;
            fire     = 1'b1;
          end else begin
            state_nx    = WAIT;
            wait_cnt_nx = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        if (!mem_read) begin
          state_nx    = IDLE;
          wait_cnt_nx = '0;
        end else if (wait_cnt == 4'd1) begin
          state_nx    = DATA;
          fire        = 1'b1;
          wait_cnt_nx = '0;
        end else begin
          wait_cnt_nx = wait_cnt - 4'd1;
        end
      end
      DATA: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      data_ready <= 1'b0;
      bus_out    <= '0;
    end else begin
      state      <= state_nx;
      wait_cnt   <= wait_cnt_nx;
      data_ready <= fire;
      bus_out    <= fire ? rd_fmt : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (load_req) begin
      lat_addr <= addr;
      lat_size <= mem_size;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_write && wr_in_range) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (wr_be[b]) ram[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  assign mem_data_ready = data_ready;
  assign mem_bus_drive  = data_ready;
  assign mem_bus_out    = bus_out;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (WAIT_STATES 0/1/3) share one stimulus stream.
module tb_mem_responder;

  localparam int NI = 3;
  localparam logic [3:0] SZ_W = 4'b0000, SZ_LB = 4'b1000, SZ_LBU = 4'b0100,
                         SZ_LH = 4'b0010, SZ_LHU = 4'b0001;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] addr = '0, bus = '0;
  logic        mem_read = 1'b0, mem_write = 1'b0, mem_addr_ready = 1'b0;
  logic [3:0]  mem_size = '0;
  logic        rdy [NI];
  logic        drv [NI];
  logic [31:0] dout [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mem_responder #(.WAIT_STATES(g == 0 ? 0 : (g == 1 ? 1 : 3))) u_dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .addr           (addr),
      .bus            (bus),
      .mem_read       (mem_read),
      .mem_write      (mem_write),
      .mem_size       (mem_size),
      .mem_addr_ready (mem_addr_ready),
      .mem_data_ready (rdy[g]),
      .mem_bus_out    (dout[g]),
      .mem_bus_drive  (drv[g])
    );
  end

  // Behavioural model: sparse word memory plus per-instance pending-read deadlines.
  function automatic int unsigned ws_of(int k);
    return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
  endfunction

  bit [31:0]   mm [int unsigned];
  int unsigned cyc = 0;
  bit          model_live = 0;
  bit          pend [NI];
  int unsigned due [NI];
  int unsigned next_ok [NI];
  logic [31:0] paddr [NI];
  logic [3:0]  psize [NI];
  logic        exp_rdy [NI];
  logic [31:0] exp_dat [NI];

  function automatic bit [31:0] load_val(logic [31:0] a, logic [3:0] s);
    bit [31:0] w, b, h;
    if (a >= 32'h80000) return 32'h0;
    w = mm.exists(a >> 2) ? mm[a >> 2] : 32'h0;
    b = (w >> (8 * int'(a[1:0]))) & 32'hFF;
    h = (w >> (16 * int'(a[1]))) & 32'hFFFF;
    case (s)
      SZ_LB:   return b[7] ? (b | 32'hFFFFFF00) : b;
      SZ_LBU:  return b;
      SZ_LH:   return h[15] ? (h | 32'hFFFF0000) : h;
      SZ_LHU:  return h;
      default: return w;
    endcase
  endfunction

  function automatic void store(logic [31:0] a, logic [31:0] d, logic [3:0] s);
    bit [31:0] old, mask, val;
    if (a >= 32'h80000) return;
    old = mm.exists(a >> 2) ? mm[a >> 2] : 32'h0;
    if (s == SZ_LB) begin
      mask = 32'hFF << (8 * int'(a[1:0]));
      val  = (d & 32'hFF) << (8 * int'(a[1:0]));
    end else if (s == SZ_LH) begin
      mask = 32'hFFFF << (16 * int'(a[1]));
      val  = (d & 32'hFFFF) << (16 * int'(a[1]));
    end else begin
      mask = 32'hFFFFFFFF;
      val  = d;
    end
    mm[a >> 2] = (old & ~mask) | (val & mask);
  endfunction

  always @(posedge clk) begin
    cyc++;
    for (int k = 0; k < NI; k++) begin
      if (!reset_n) begin
        pend[k] = 0; exp_rdy[k] = 1'b0; exp_dat[k] = '0; next_ok[k] = cyc + 1;
      end else begin
        exp_rdy[k] = 1'b0; exp_dat[k] = '0;
        if (pend[k]) begin
          if (!mem_read) pend[k] = 0;
          else if (cyc == due[k]) begin
            exp_rdy[k] = 1'b1; exp_dat[k] = load_val(paddr[k], psize[k]);
            pend[k] = 0; next_ok[k] = cyc + 2;
          end
        end else if (cyc >= next_ok[k] && mem_read && mem_addr_ready && !mem_write) begin
          if (ws_of(k) == 0) begin
            exp_rdy[k] = 1'b1; exp_dat[k] = load_val(addr, mem_size); next_ok[k] = cyc + 2;
          end else begin
            pend[k] = 1; due[k] = cyc + ws_of(k); paddr[k] = addr; psize[k] = mem_size;
          end
        end
      end
    end
    if (mem_write) store(addr, bus, mem_size);
    if (!reset_n) model_live = 1;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (model_live) begin
      for (int k = 0; k < NI; k++) begin
        chk($sformatf("rdy[%0d]@%0d", k, cyc), {31'b0, rdy[k]}, {31'b0, exp_rdy[k]});
        chk($sformatf("drv[%0d]@%0d", k, cyc), {31'b0, drv[k]}, {31'b0, exp_rdy[k]});
        chk($sformatf("dout[%0d]@%0d", k, cyc), dout[k], exp_dat[k]);
      end
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    addr = a; bus = d; mem_size = s; mem_write = 1'b1;
    step();
    mem_write = 1'b0;
    step();
  endtask

  logic [31:0] got [NI];
  int          first [NI];
  int          pulses [NI];

  // Read over an 8-cycle window; mem_read drops after 'hold' cycles, optional write at wr_at.
  task automatic rd(input logic [31:0] a, input logic [3:0] s, input int hold,
                    input int wr_at, input logic [31:0] wd);
    for (int k = 0; k < NI; k++) begin got[k] = 'x; first[k] = 0; pulses[k] = 0; end
    addr = a; mem_size = s; mem_read = 1'b1; mem_addr_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      mem_addr_ready = 1'b0;
      if (i == hold) mem_read = 1'b0;
      if (i == wr_at) begin mem_write = 1'b1; bus = wd; end
      if (i == wr_at + 1) mem_write = 1'b0;
      for (int k = 0; k < NI; k++) begin
        if (rdy[k] === 1'b1) begin
          pulses[k]++;
          if (first[k] == 0) first[k] = i;
          got[k] = dout[k];
        end
      end
    end
    mem_read = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic rd_all(string name, input logic [31:0] a, input logic [3:0] s, input logic [31:0] exp);
    rd(a, s, 8, 0, '0);
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("%s_data[%0d]", name, k), got[k], exp);
      chk($sformatf("%s_pulses[%0d]", name, k), pulses[k], 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) step();
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("reset_rdy[%0d]", k), {31'b0, rdy[k]}, 32'h0);
      chk($sformatf("reset_dout[%0d]", k), dout[k], 32'h0);
    end
    reset_n = 1'b1;
    step();

    wr(32'h100, 32'hDEADBEEF, SZ_W);
    rd(32'h100, SZ_W, 8, 0, '0);
    chk("lat_ws0", first[0], 1);
    chk("lat_ws1", first[1], 2);
    chk("lat_ws3", first[2], 4);
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("word_data[%0d]", k), got[k], 32'hDEADBEEF);
      chk($sformatf("word_pulses[%0d]", k), pulses[k], 1);
    end

    rd_all("lb103", 32'h103, SZ_LB, 32'hFFFFFFDE);
    rd_all("lbu103", 32'h103, SZ_LBU, 32'h000000DE);
    rd_all("lh102", 32'h102, SZ_LH, 32'hFFFFDEAD);
    rd_all("lhu100", 32'h100, SZ_LHU, 32'h0000BEEF);

    wr(32'h101, 32'h00000055, SZ_LB);
    rd_all("sb101", 32'h100, SZ_W, 32'hDEAD55EF);
    wr(32'h102, 32'h00001234, SZ_LH);
    rd_all("sh102", 32'h100, SZ_W, 32'h123455EF);

    rd(32'h100, SZ_W, 1, 0, '0);
    chk("abort_pulses_ws0", pulses[0], 1);
    chk("abort_pulses_ws1", pulses[1], 0);
    chk("abort_pulses_ws3", pulses[2], 0);
    rd_all("after_abort", 32'h100, SZ_W, 32'h123455EF);

    wr(32'h200, 32'h11111111, SZ_W);
    rd(32'h200, SZ_W, 8, 2, 32'hCAFEF00D);
    chk("wr_in_wait_ws1", got[1], 32'h11111111);
    chk("wr_in_wait_ws3", got[2], 32'hCAFEF00D);

    wr(32'h0, 32'h0BADF00D, SZ_W);
    wr(32'h80000, 32'hFFFFFFFF, SZ_W);
    rd_all("oor_read", 32'h80000, SZ_W, 32'h0);
    rd_all("oor_alias", 32'h0, SZ_W, 32'h0BADF00D);

    addr = 32'h100; mem_size = SZ_W; mem_read = 1'b1; mem_addr_ready = 1'b1;
    step();
    chk("rst_pre_ws0", {31'b0, rdy[0]}, 32'h1);
    mem_addr_ready = 1'b0;
    reset_n = 1'b0;
    step();
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("rst_mid_rdy[%0d]", k), {31'b0, rdy[k]}, 32'h0);
      chk($sformatf("rst_mid_dout[%0d]", k), dout[k], 32'h0);
    end
    reset_n = 1'b1;
    for (int k = 0; k < NI; k++) pulses[k] = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      for (int k = 0; k < NI; k++) if (rdy[k] === 1'b1) pulses[k]++;
    end
    mem_read = 1'b0;
    for (int k = 0; k < NI; k++) chk($sformatf("rst_no_pulse[%0d]", k), pulses[k], 0);

    rd(32'h102, SZ_LHU, 8, 0, '0);
    chk("post_rst_lat_ws0", first[0], 1);
    chk("post_rst_data_ws0", got[0], 32'h00001234);
    chk("post_rst_data_ws3", got[2], 32'h00001234);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
